// File: rtl/thermo_stream_checker_if.sv
// -----------------------------------------------------------------------------
// thermo_stream_checker_if
//   Bundles the code stream handshake, the result fields and the error
//   tracking signals of thermo_stream_checker.
//   master : the producer/consumer side (drives in_valid, codeIn, out_ready,
//            err_clear).
//   slave  : the checker side (drives in_ready, result fields and error state).
//   Parameters:
//     WIDTH : code width in bits (>= 2)
//     CNT_W : error counter width in bits (>= 1)
//     LVL_W : level width, derived from WIDTH
// -----------------------------------------------------------------------------
interface thermo_stream_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int LVL_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] codeIn;
    logic             out_valid;
    logic             out_ready;
    logic             isThermometer;
    logic [LVL_W-1:0] out_level;
    logic             out_fixed;
    logic [CNT_W-1:0] err_count;
    logic             err_flag;
    logic             err_clear;

    modport master (
        output in_valid, codeIn, out_ready, err_clear,
        input  in_ready, out_valid, isThermometer, out_level, out_fixed,
               err_count, err_flag
    );

    modport slave (
        input  in_valid, codeIn, out_ready, err_clear,
        output in_ready, out_valid, isThermometer, out_level, out_fixed,
               err_count, err_flag
    );
endinterface

// File: rtl/thermo_stream_checker.sv
// -----------------------------------------------------------------------------
// thermo_stream_checker
//   Streams WIDTH-bit codes over valid/ready, registers whether each accepted
//   code is a thermometer code (2^k - 1, 1 <= k <= WIDTH) together with its
//   level k, and keeps a saturating count plus a sticky flag of accepted
//   invalid codes. One result register, no skid buffer: in_ready is
//   !out_valid || out_ready.
//
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous, active-high reset
//     bus   : thermo_stream_checker_if.slave
//             in_valid/in_ready/codeIn       input handshake and code
//             out_valid/out_ready            result handshake
//             isThermometer/out_level/out_fixed  registered result fields
//             err_count/err_flag/err_clear   error tracking
//
//   Optional feature macro: THERMO_BUBBLE_FIX_EN
//     Defined     : majority-of-3 bubble filter ahead of the check; out_fixed
//                   reports whether the filter changed the code.
//     Not defined : raw code is checked; out_fixed is constant 0.
// -----------------------------------------------------------------------------
module thermo_stream_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    thermo_stream_checker_if.slave bus
);
    localparam int LVL_W = $clog2(WIDTH + 1);

    // ---------------------------------------------------------------- filter
    logic [WIDTH-1:0] code_fix;

`ifdef THERMO_BUBBLE_FIX_EN
    // Pad with a 1 below bit 0 and a 0 above the MSB so the end bits see the
    // implied thermometer boundary.
    logic [WIDTH+1:0] code_ext;
    assign code_ext = {1'b0, bus.codeIn, 1'b1};

    for (genvar i = 0; i < WIDTH; i++) begin : g_maj
        assign code_fix[i] = (code_ext[i]   & code_ext[i+1]) |
                             (code_ext[i]   & code_ext[i+2]) |
                             (code_ext[i+1] & code_ext[i+2]);
    end
`else
    assign code_fix = bus.codeIn;
`endif

    // ----------------------------------------------------------------- check
    logic             is_thermo_c;
    logic             fixed_c;
    logic [LVL_W-1:0] ones_c;
    logic [LVL_W-1:0] level_c;

    // x & (x+1) == 0 only for runs of ones starting at bit 0 (all-ones wraps
    // to zero); the nonzero test rules out the empty code.
    assign is_thermo_c = (code_fix != '0) &&
                         ((code_fix & (code_fix + WIDTH'(1))) == '0);
    assign fixed_c     = (code_fix != bus.codeIn);

    always_comb begin
        ones_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_c = ones_c + LVL_W'(code_fix[i]);
        end
    end

    assign level_c = is_thermo_c ? ones_c : '0;

    // ------------------------------------------------------------- registers
    logic             valid_q,  valid_d;
    logic             thermo_q, thermo_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             fixed_q,  fixed_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             flag_q,   flag_d;
    logic             accept;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d  = valid_q;
        thermo_d = thermo_q;
        level_d  = level_q;
        fixed_d  = fixed_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;

        if (accept) begin
            valid_d  = 1'b1;
            thermo_d = is_thermo_c;
            level_d  = level_c;
            fixed_d  = fixed_c;
        end else if (bus.out_ready) begin
            // Result consumed with nothing new behind it; fields keep value.
            valid_d  = 1'b0;
        end

        // Clear wins over an invalid code accepted in the same cycle.
        if (bus.err_clear) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (accept && !is_thermo_c) begin
            flag_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            thermo_q <= 1'b0;
            level_q  <= '0;
            fixed_q  <= 1'b0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            thermo_q <= thermo_d;
            level_q  <= level_d;
            fixed_q  <= fixed_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.isThermometer = thermo_q;
    assign bus.out_level     = level_q;
    assign bus.out_fixed     = fixed_q;
    assign bus.err_count     = cnt_q;
    assign bus.err_flag      = flag_q;
endmodule

// File: tb/tb_thermo_stream_checker.sv
// Bench for thermo_stream_checker: instance A (WIDTH=8, CNT_W=8) carries the
// directed and randomized streams, instance B (WIDTH=8, CNT_W=2) covers
// counter saturation. Inputs change on the falling edge; outputs are read on
// the falling edge (or 1 time unit after an input change for in_ready).
module tb_thermo_stream_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    thermo_stream_checker_if #(.WIDTH(8), .CNT_W(8)) ifa ();
    thermo_stream_checker_if #(.WIDTH(8), .CNT_W(2)) ifb ();

    thermo_stream_checker #(.WIDTH(8), .CNT_W(8)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
    thermo_stream_checker #(.WIDTH(8), .CNT_W(2)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

    // ---------------------------------------------------------------- model
    // Classifies a code directly from the definition: optionally run the
    // majority filter, then search for k with code == 2^k - 1.
    function automatic void ref_eval(input logic [7:0] code, output logic th,
                                     output logic [3:0] lv, output logic fx);
        logic [7:0] c;
`ifdef THERMO_BUBBLE_FIX_EN
        logic [9:0] ext;
        ext = {1'b0, code, 1'b1};
        for (int i = 0; i < 8; i++)
            c[i] = (int'(ext[i]) + int'(ext[i+1]) + int'(ext[i+2])) >= 2;
`else
        c = code;
`endif
        th = 1'b0;
        lv = 4'd0;
        for (int k = 1; k <= 8; k++)
            if (c == 8'((1 << k) - 1)) begin th = 1'b1; lv = 4'(k); end
        fx = (c != code);
    endfunction

    logic       r_th, r_fx;
    logic [3:0] r_lv;
    logic       m_valid, m_thermo, m_fixed, m_flag;
    logic [3:0] m_level;
    int         m_cnt;
    logic       m_acc;

    always_comb ref_eval(ifa.codeIn, r_th, r_lv, r_fx);
    assign m_acc = ifa.in_valid && (!m_valid || ifa.out_ready);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_thermo <= 1'b0; m_level <= 4'd0; m_fixed <= 1'b0;
            m_cnt <= 0; m_flag <= 1'b0;
        end else begin
            if (m_acc) begin
                m_valid <= 1'b1; m_thermo <= r_th; m_level <= r_lv; m_fixed <= r_fx;
            end else if (ifa.out_ready) begin
                m_valid <= 1'b0;
            end
            if (ifa.err_clear) begin
                m_cnt <= 0; m_flag <= 1'b0;
            end else if (m_acc && !r_th) begin
                m_flag <= 1'b1;
                m_cnt  <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifa.in_valid = 1'b0; ifa.codeIn = 8'h00; ifa.out_ready = 1'b1; ifa.err_clear = 1'b0;
        ifb.in_valid = 1'b0; ifb.codeIn = 8'h00; ifb.out_ready = 1'b1; ifb.err_clear = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed, ifa.err_count, ifa.err_flag, ifa.in_ready} !== 16'h0001) begin
            n_err++;
            $display("FAIL reset_a got v=%b t=%b l=%0d f=%b c=%0d e=%b rdy=%b want all 0, rdy=1",
                     ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed, ifa.err_count, ifa.err_flag, ifa.in_ready);
        end
        n_vec++;
        if ({ifb.out_valid, ifb.isThermometer, ifb.out_level, ifb.out_fixed, ifb.err_count, ifb.err_flag, ifb.in_ready} !== 10'h001) begin
            n_err++;
            $display("FAIL reset_b got v=%b c=%0d e=%b rdy=%b want 0 0 0 1", ifb.out_valid, ifb.err_count, ifb.err_flag, ifb.in_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] codes [7] = '{8'h01, 8'h03, 8'h07, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        int         lvls  [7] = '{1, 2, 3, 5, 6, 7, 8};
        do_reset();
        n_vec++;
        if (ifa.out_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_idle out_valid got %b want 0", ifa.out_valid);
        end
        for (int i = 0; i < 7; i++) begin
            ifa.in_valid = 1'b1; ifa.codeIn = codes[i];
            #1;
            n_vec++;
            if (ifa.in_ready !== 1'b1) begin
                n_err++; $display("FAIL stream_ready[%0d] got %b want 1", i, ifa.in_ready);
            end
            tick();
            n_vec++;
            if ({ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.err_count} !== {1'b1, 1'b1, 4'(lvls[i]), 8'd0}) begin
                n_err++;
                $display("FAIL stream[%0d] code %h got v=%b t=%b l=%0d c=%0d want v=1 t=1 l=%0d c=0",
                         i, codes[i], ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.err_count, lvls[i]);
            end
        end
        ifa.in_valid = 1'b0;
        tick();
        n_vec++;
        if ({ifa.out_valid, ifa.out_level} !== {1'b0, 4'd8}) begin
            n_err++; $display("FAIL stream_drain got v=%b l=%0d want v=0 l=8 (held)", ifa.out_valid, ifa.out_level);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] codes [2] = '{8'h00, 8'h09};
        logic th, fx; logic [3:0] lv;
        int   exp_cnt = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ifa.in_valid = 1'b1; ifa.codeIn = codes[i];
            ref_eval(codes[i], th, lv, fx);
            if (!th) exp_cnt++;
            tick();
            n_vec++;
            if ({ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed} !== {1'b1, th, lv, fx}) begin
                n_err++;
                $display("FAIL invalid[%0d] code %h got t=%b l=%0d f=%b want t=%b l=%0d f=%b",
                         i, codes[i], ifa.isThermometer, ifa.out_level, ifa.out_fixed, th, lv, fx);
            end
        end
        ifa.in_valid = 1'b0;
`ifndef THERMO_BUBBLE_FIX_EN
        n_vec++;
        if (exp_cnt != 2 || ifa.err_count !== 8'd2) begin
            n_err++; $display("FAIL invalid_count got %0d want 2", ifa.err_count);
        end
`endif
        n_vec++;
        if ({ifa.err_count, ifa.err_flag} !== {8'(exp_cnt), 1'b1}) begin
            n_err++; $display("FAIL invalid_err got c=%0d e=%b want c=%0d e=1", ifa.err_count, ifa.err_flag, exp_cnt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        ifa.in_valid = 1'b1; ifa.codeIn = 8'h07;
        tick();
        ifa.out_ready = 1'b0; ifa.codeIn = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (ifa.in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_ready[%0d] got %b want 0", i, ifa.in_ready);
            end
            tick();
            n_vec++;
            if ({ifa.out_valid, ifa.isThermometer, ifa.out_level} !== {1'b1, 1'b1, 4'd3}) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%b t=%b l=%0d want v=1 t=1 l=3", i, ifa.out_valid, ifa.isThermometer, ifa.out_level);
            end
        end
        ifa.out_ready = 1'b1;
        #1;
        n_vec++;
        if (ifa.in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready got %b want 1", ifa.in_ready);
        end
        tick();
        ifa.in_valid = 1'b0;
        n_vec++;
        if ({ifa.out_valid, ifa.isThermometer, ifa.out_level} !== {1'b1, 1'b1, 4'd4}) begin
            n_err++; $display("FAIL bp_next got v=%b t=%b l=%0d want v=1 t=1 l=4", ifa.out_valid, ifa.isThermometer, ifa.out_level);
        end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ifb.in_valid = 1'b1; ifb.codeIn = 8'h00;
            tick();
            n_vec++;
            if ({ifb.err_count, ifb.err_flag} !== {2'((i + 1 > 3) ? 3 : i + 1), 1'b1}) begin
                n_err++; $display("FAIL sat[%0d] got c=%0d e=%b want c=%0d e=1", i, ifb.err_count, ifb.err_flag, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        ifb.err_clear = 1'b1;
        tick();
        ifb.err_clear = 1'b0; ifb.in_valid = 1'b0;
        n_vec++;
        if ({ifb.out_valid, ifb.isThermometer, ifb.err_count, ifb.err_flag} !== 5'b10000) begin
            n_err++; $display("FAIL sat_clear got v=%b t=%b c=%0d e=%b want v=1 t=0 c=0 e=0", ifb.out_valid, ifb.isThermometer, ifb.err_count, ifb.err_flag);
        end
        tick();
    endtask

    task automatic test_bubble();
        do_reset();
        ifa.in_valid = 1'b1; ifa.codeIn = 8'h1B;
        tick();
        n_vec++;
`ifdef THERMO_BUBBLE_FIX_EN
        if ({ifa.isThermometer, ifa.out_level, ifa.out_fixed} !== {1'b1, 4'd5, 1'b1}) begin
            n_err++; $display("FAIL bubble_1B got t=%b l=%0d f=%b want t=1 l=5 f=1", ifa.isThermometer, ifa.out_level, ifa.out_fixed);
        end
`else
        if ({ifa.isThermometer, ifa.out_level, ifa.out_fixed} !== {1'b0, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL bubble_1B got t=%b l=%0d f=%b want t=0 l=0 f=0", ifa.isThermometer, ifa.out_level, ifa.out_fixed);
        end
`endif
        ifa.codeIn = 8'h00;
        tick();
        ifa.in_valid = 1'b0;
        n_vec++;
        if ({ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL bubble_00 got t=%b l=%0d f=%b want t=0 l=0 f=0", ifa.isThermometer, ifa.out_level, ifa.out_fixed);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ifa.in_valid  = ($urandom_range(0, 3) != 0);
            ifa.codeIn    = $urandom_range(0, 1) ? 8'((1 << $urandom_range(1, 8)) - 1) : 8'($urandom);
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            ifa.err_clear = ($urandom_range(0, 31) == 0);
            #1;
            n_vec++;
            if (ifa.in_ready !== (!m_valid || ifa.out_ready)) begin
                n_err++; $display("FAIL rand_ready[%0d] got %b want %b", i, ifa.in_ready, !m_valid || ifa.out_ready);
            end
            tick();
            n_vec++;
            if ({ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed, ifa.err_count, ifa.err_flag} !==
                {m_valid, m_thermo, m_level, m_fixed, 8'(m_cnt), m_flag}) begin
                n_err++;
                $display("FAIL rand[%0d] got v=%b t=%b l=%0d f=%b c=%0d e=%b want v=%b t=%b l=%0d f=%b c=%0d e=%b", i,
                         ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed, ifa.err_count, ifa.err_flag,
                         m_valid, m_thermo, m_level, m_fixed, m_cnt, m_flag);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        ifa.in_valid = 1'b1; ifa.codeIn = 8'h00;
        tick();
        ifa.codeIn = 8'h05;
        tick();
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        n_vec++;
        if ({ifa.out_valid, ifa.err_count, ifa.err_flag} !== {1'b1, 8'(m_cnt), 1'b1} || m_cnt < 1) begin
            n_err++; $display("FAIL areset_pre got v=%b c=%0d e=%b want v=1 c=%0d e=1", ifa.out_valid, ifa.err_count, ifa.err_flag, m_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed, ifa.err_count, ifa.err_flag} !== 15'd0) begin
            n_err++;
            $display("FAIL areset got v=%b t=%b l=%0d f=%b c=%0d e=%b want all 0",
                     ifa.out_valid, ifa.isThermometer, ifa.out_level, ifa.out_fixed, ifa.err_count, ifa.err_flag);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_invalid();
        test_backpressure();
        test_saturate();
        test_bubble();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/thermo_stream_checker.md
# thermo_stream_checker

Parametrised, pipelined successor to the 8-bit combinational thermometer detector. Accepts a stream of WIDTH-bit codes over a valid/ready handshake, registers per-code validity and decoded level (binary count of ones), and tracks a saturating error count plus a sticky error flag. It sits between flash-ADC / DAC-segment front ends and downstream binary logic.

## Interface
- WIDTH, 8: code width in bits, ≥2.
- CNT_W, 8: error counter width in bits, ≥1.
- LVL_W, $clog2(WIDTH+1): level output width. Derived; not overridden.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  code on codeIn is offered.
- in_ready  output  1  block can accept a code this cycle.
- codeIn  input  WIDTH  input code.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream consumes the result this cycle.
- isThermometer  output  1  registered code is a valid thermometer code.
- out_level  output  LVL_W  number of ones when valid, else 0.
- out_fixed  output  1  bubble correction altered the code.
- err_count  output  CNT_W  saturating count of accepted invalid codes.
- err_flag  output  1  sticky: set once any invalid code is accepted.
- err_clear  input  1  synchronous clear of err_count and err_flag.

## Operation
- Valid thermometer code: codeIn == 2^k − 1 for some 1 ≤ k ≤ WIDTH. All-zero is invalid. Level = k.
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready, i.e. combinational pass-through of out_ready. No skid buffer.
- On accept, the result register loads isThermometer, out_level and out_fixed, and out_valid is set.
- When out_valid && out_ready and no accept occurs in the same cycle, out_valid clears. Result fields hold their last values.
- While out_valid && !out_ready, all result fields are held stable.
- Error tracking applies on each accepted invalid code:
  - err_flag is set to 1.
  - err_count increments by 1 and saturates at 2^CNT_W − 1 (no wrap).
- err_clear zeroes err_count and err_flag. It has priority over a same-cycle invalid accept, and that error is not counted.
- Reset mid-stream discards any held result; the in-flight code is lost.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 code per cycle while out_ready is held high.
- Reset values:
  - out_valid = 0, isThermometer = 0, out_level = 0, out_fixed = 0, err_count = 0, err_flag = 0.
  - in_ready follows the rule above and is therefore 1 during reset.
- err_count and err_flag reflect an accepted code on the same edge as its result, and are visible the cycle after the accept.

## Configuration
- THERMO_BUBBLE_FIX_EN defined: a majority-of-3 bubble filter is applied before the check.
  - Corrected bit i = maj(c[i−1], c[i], c[i+1]), with c[−1] = 1 and c[WIDTH] = 0.
  - The validity check and level use the corrected code.
  - out_fixed = (corrected != codeIn).
  - The filter remains purely combinational, so latency is unchanged.
- Not defined: the raw code is checked, and out_fixed is constant 0.

## Test plan
- WIDTH=8, out_ready=1; stream 01, 03, 07, 1F, 3F, 7F, FF, one per cycle:
  - each result appears 1 cycle after its accept with isThermometer=1;
  - levels are 1, 2, 3, 5, 6, 7, 8;
  - err_count stays 0.
- Stream 00, 09 without the macro:
  - both results give isThermometer=0, out_level=0;
  - err_count=2, err_flag=1.
- Backpressure: out_ready=0 after accepting 07, with in_valid held on 0F for 3 cycles:
  - in_ready=0 and output fields stay at level 3;
  - when out_ready rises, 07 is consumed and 0F is accepted that cycle;
  - the 0F result (level 4) appears next cycle.
- CNT_W=2; feed 5 invalid codes:
  - err_count goes 1, 2, 3, 3, 3;
  - then err_clear together with an invalid accept leaves err_count=0 and err_flag=0.
- With THERMO_BUBBLE_FIX_EN, code 1B:
  - isThermometer=1, out_level=5, out_fixed=1.
  - Code 00 still gives isThermometer=0 and out_fixed=0.
- Assert reset while out_valid=1 and err_count=2:
  - out_valid, err_count, err_flag and all result fields return to 0 without waiting for a clock edge.
